// File: rtl/key_sched_seq.sv
// key_sched_seq
//   Sequential round-key scheduler. A 2*HALF_W seed is accepted over a
//   valid/ready handshake. It is then expanded into NUM_KEYS round keys, one
//   round per cycle, and the keys are stored in an internal bank. The keys are
//   then streamed out with backpressure, in forward order (k0..kN-1) or in
//   reverse order (kN-1..k0). Reverse order feeds the decrypt path.
//
//   Round i, state {L,R}:
//     k_i      = rotl(L+R, ROT) ^ (i+1)
//     next L,R = R, k_i ^ L
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   seed_valid/ready  seed handshake; ready is high only when idle
//   seed              {L0,R0}
//   seed_rev          sampled with the seed: 1 selects reverse emission order
//   abort             synchronous abort back to idle
//   key_valid/ready   key stream handshake
//   key, key_idx      round key and its generation index
//   key_last          marks the final key of the sequence
//   busy              generating or emitting
module key_sched_seq #(
  parameter int HALF_W   = 32,
  parameter int NUM_KEYS = 8,
  parameter int ROT      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        seed_valid,
  output logic                        seed_ready,
  input  logic [2*HALF_W-1:0]         seed,
  input  logic                        seed_rev,
  input  logic                        abort,
  output logic                        key_valid,
  input  logic                        key_ready,
  output logic [HALF_W-1:0]           key,
  output logic [$clog2(NUM_KEYS)-1:0] key_idx,
  output logic                        key_last,
  output logic                        busy
);

  localparam int IDX_W = $clog2(NUM_KEYS);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

  logic [1:0]        r_state;
  logic [HALF_W-1:0] r_l;
  logic [HALF_W-1:0] r_r;
  logic [HALF_W-1:0] r_key;
  logic [IDX_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_ptr;
  logic              r_rev;
  logic              r_key_valid;
  logic              r_key_last;
  logic [HALF_W-1:0] r_bank [NUM_KEYS];

  logic [HALF_W-1:0] w_sum;
  logic [HALF_W-1:0] w_rot;
  logic [HALF_W-1:0] w_k;
  logic [IDX_W-1:0]  w_ptr_nxt;

  assign w_sum     = r_l + r_r;
  assign w_rot     = (w_sum << ROT) | (w_sum >> (HALF_W - ROT));
  assign w_k       = w_rot ^ (HALF_W'(r_cnt) + HALF_W'(1));
  assign w_ptr_nxt = r_rev ? (r_ptr - 1'b1) : (r_ptr + 1'b1);

  // The key bank holds data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_GEN) begin
      r_bank[r_cnt] <= w_k;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_l         <= '0;
      r_r         <= '0;
      r_key       <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_rev       <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_last  <= 1'b0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_key_valid <= 1'b0;
      r_key_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (seed_valid) begin
            r_state <= S_GEN;
            r_l     <= seed[2*HALF_W-1:HALF_W];
            r_r     <= seed[HALF_W-1:0];
            r_rev   <= seed_rev;
            r_cnt   <= '0;
          end
        end
        S_GEN: begin
          r_l   <= r_r;
          r_r   <= w_k ^ r_l;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IDX) begin
            r_state     <= S_EMIT;
            r_key_valid <= 1'b1;
            // The last round's key reaches the bank only at this edge.
            // Reverse order therefore takes that key straight from the round logic.
            r_key       <= r_rev ? w_k : r_bank[0];
            r_ptr       <= r_rev ? LAST_IDX : '0;
            // With at least two keys, the first key emitted is never the last one.
            r_key_last  <= 1'b0;
          end
        end
        S_EMIT: begin
          if (key_ready) begin
            if (r_key_last) begin
              r_state     <= S_IDLE;
              r_key_valid <= 1'b0;
              r_key_last  <= 1'b0;
            end else begin
              r_ptr      <= w_ptr_nxt;
              r_key      <= r_bank[w_ptr_nxt];
              r_key_last <= r_rev ? (w_ptr_nxt == '0) : (w_ptr_nxt == LAST_IDX);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign seed_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_GEN) || (r_state == S_EMIT);
  assign key_valid  = r_key_valid;
  assign key        = r_key;
  assign key_idx    = r_ptr;
  assign key_last   = r_key_last;

endmodule

// File: tb/tb_key_sched_seq.sv
module tb_key_sched_seq;

  typedef struct {
    logic [31:0] key;
    int          idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;

  // Instance A: HALF_W=32, NUM_KEYS=8, ROT=3
  logic        sv_a, rdy_a, rev_a, abort_a, kv_a, kr_a, last_a, busy_a;
  logic [63:0] seed_a;
  logic [31:0] key_a;
  logic [2:0]  idx_a;

  // Instance B: HALF_W=8, NUM_KEYS=2, ROT=3
  logic        sv_b, rdy_b, rev_b, abort_b, kv_b, kr_b, last_b, busy_b;
  logic [15:0] seed_b;
  logic [7:0]  key_b;
  logic [0:0]  idx_b;

  exp_t        sb_a[$];
  exp_t        sb_b[$];
  logic [31:0] cap[$];
  logic        cap_en = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          hs_cyc = 0;
  int          last_hs_cyc = 0;
  logic        wait_first = 1'b0;
  logic        rnd_mode = 1'b0;
  logic        ready_force = 1'b1;

  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [31:0] prev_key;
  logic [2:0]  prev_idx;
  logic        prev_last;

  key_sched_seq #(.HALF_W(32), .NUM_KEYS(8), .ROT(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv_a), .seed_ready(rdy_a), .seed(seed_a),
    .seed_rev(rev_a), .abort(abort_a), .key_valid(kv_a), .key_ready(kr_a), .key(key_a),
    .key_idx(idx_a), .key_last(last_a), .busy(busy_a)
  );

  key_sched_seq #(.HALF_W(8), .NUM_KEYS(2), .ROT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .seed_valid(sv_b), .seed_ready(rdy_b), .seed(seed_b),
    .seed_rev(rev_b), .abort(abort_b), .key_valid(kv_b), .key_ready(kr_b), .key(key_b),
    .key_idx(idx_b), .key_last(last_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: returns key idx for the given seed, computed in width hw.
  function automatic logic [31:0] mk(input logic [63:0] s, input int hw, input int rot, input int idx);
    logic [31:0] m, l, r, k, t;
    m = (hw == 32) ? 32'hFFFF_FFFF : ((32'd1 << hw) - 32'd1);
    l = 32'(s >> hw) & m;
    r = s[31:0] & m;
    k = '0;
    for (int i = 0; i <= idx; i++) begin
      t = (l + r) & m;
      k = ((t << rot) | (t >> (hw - rot))) & m;
      k = k ^ 32'(i + 1);
      t = k ^ l;
      l = r;
      r = t;
    end
    return k;
  endfunction

  task automatic push_exp(input logic sel_b, input logic [63:0] s, input logic rev);
    exp_t e;
    int   hw = sel_b ? 8 : 32;
    int   n  = sel_b ? 2 : 8;
    for (int i = 0; i < n; i++) begin
      e.idx  = rev ? (n - 1 - i) : i;
      e.key  = mk(s, hw, 3, e.idx);
      e.last = (i == n - 1);
      if (sel_b) sb_b.push_back(e);
      else       sb_a.push_back(e);
    end
  endtask

  task automatic send_a(input logic [63:0] s, input logic rev, input logic keep);
    int n = 0;
    seed_a = s;
    rev_a  = rev;
    sv_a   = 1'b1;
    @(negedge clk);
    while (!rdy_a && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("seed_accept_a", rdy_a, 1);
    hs_cyc     = cyc;
    wait_first = 1'b1;
    push_exp(1'b0, s, rev);
    @(posedge clk); #1;
    if (!keep) sv_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int   n  = 0;
    logic ok = 1'b0;
    while (n < 2000 && !ok) begin
      @(negedge clk);
      ok = (sb_a.size() == 0) && !busy_a;
      n++;
    end
    chk("done_a", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic [15:0] s, input logic rev);
    int   n  = 0;
    logic ok = 1'b0;
    seed_b = s;
    rev_b  = rev;
    sv_b   = 1'b1;
    @(negedge clk);
    while (!rdy_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("seed_accept_b", rdy_b, 1);
    push_exp(1'b1, 64'(s), rev);
    @(posedge clk); #1;
    sv_b = 1'b0;
    n = 0;
    while (n < 100 && !ok) begin
      @(negedge clk);
      ok = (sb_b.size() == 0) && !busy_b;
      n++;
    end
    chk("done_b", ok, 1);
    @(posedge clk); #1;
  endtask

  // key_ready driver for instance A
  initial begin
    kr_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      kr_a = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitor A: scoreboard pop, hold during stall, first-key latency
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        chk("hold_valid", kv_a, 1);
        chk("hold_key", key_a, prev_key);
        chk("hold_idx", idx_a, prev_idx);
        chk("hold_last", last_a, prev_last);
      end
      if (kv_a && wait_first) begin
        chk("latency", cyc - hs_cyc, 9);
        wait_first = 1'b0;
      end
      if (kv_a && kr_a) begin
        if (sb_a.size() == 0) begin
          chk("sb_a_underflow", sb_a.size(), 1);
        end else begin
          e = sb_a.pop_front();
          chk("key_a", key_a, e.key);
          chk("idx_a", idx_a, e.idx);
          chk("last_a", last_a, e.last);
          n_pop++;
          if (cap_en) cap.push_back(key_a);
        end
        if (last_a) last_hs_cyc = cyc;
      end
      prev_stall = kv_a && !kr_a;
      prev_abort = abort_a;
      prev_key   = key_a;
      prev_idx   = idx_a;
      prev_last  = last_a;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && kv_b && kr_b) begin
      if (sb_b.size() == 0) begin
        chk("sb_b_underflow", sb_b.size(), 1);
      end else begin
        e = sb_b.pop_front();
        chk("key_b", key_b, e.key);
        chk("idx_b", idx_b, e.idx);
        chk("last_b", last_b, e.last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n = 1'b1;
    sv_a = 1'b0; rev_a = 1'b0; abort_a = 1'b0; seed_a = '0;
    sv_b = 1'b0; rev_b = 1'b0; abort_b = 1'b0; seed_b = '0; kr_b = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", rdy_a, 1);
    chk("rst_valid", kv_a, 0);
    chk("rst_key", key_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid_b", kv_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy_a, 1);
    @(posedge clk); #1;

    // T1: zero seed, forward order
    cap.delete();
    cap_en = 1'b1;
    send_a(64'd0, 1'b0, 1'b0);
    wait_done_a();
    cap_en = 1'b0;
    chk("t1_count", cap.size(), 8);
    if (cap.size() >= 3) begin
      chk("t1_k0", cap[0], 32'h0000_0001);
      chk("t1_k1", cap[1], 32'h0000_000A);
      chk("t1_k2", cap[2], 32'h0000_005B);
    end

    // T2: zero seed, reverse order
    send_a(64'd0, 1'b1, 1'b0);
    wait_done_a();

    // T3: random stalls over random seeds
    rnd_mode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send_a({$urandom, $urandom}, 1'(i % 2), 1'b0);
      wait_done_a();
    end
    rnd_mode = 1'b0;

    // T4: seed_valid held across a whole sequence
    send_a({$urandom, $urandom}, 1'b0, 1'b1);
    send_a({$urandom, $urandom}, 1'b1, 1'b0);
    chk("t4_accept_gap", hs_cyc - last_hs_cyc, 1);
    wait_done_a();

    // T5a: abort in GEN cycle 3
    send_a({$urandom, $urandom}, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    sb_a.delete();
    wait_first = 1'b0;
    chk("abort_gen_valid", kv_a, 0);
    chk("abort_gen_ready", rdy_a, 1);
    chk("abort_gen_busy", busy_a, 0);
    send_a({$urandom, $urandom}, 1'b1, 1'b0);
    wait_done_a();

    // T5b: abort in EMIT after two keys
    base = n_pop;
    send_a({$urandom, $urandom}, 1'b1, 1'b0);
    n = 0;
    while (n_pop < base + 2 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_emit_reached", n_pop - base >= 2, 1);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    sb_a.delete();
    wait_first = 1'b0;
    chk("abort_emit_valid", kv_a, 0);
    chk("abort_emit_ready", rdy_a, 1);
    chk("abort_emit_busy", busy_a, 0);
    send_a({$urandom, $urandom}, 1'b0, 1'b0);
    wait_done_a();

    // abort together with a seed offer in IDLE: the seed must not be taken
    seed_a  = {$urandom, $urandom};
    sv_a    = 1'b1;
    abort_a = 1'b1;
    @(posedge clk); #1;
    sv_a    = 1'b0;
    abort_a = 1'b0;
    chk("abort_idle_busy", busy_a, 0);
    chk("abort_idle_ready", rdy_a, 1);
    chk("abort_idle_valid", kv_a, 0);

    // T6: asynchronous reset mid-EMIT while stalled
    ready_force = 1'b0;
    @(posedge clk); #1;
    send_a({$urandom, $urandom}, 1'b0, 1'b0);
    n = 0;
    while (!kv_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_emit_reached", kv_a, 1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", kv_a, 0);
    chk("t6_key", key_a, 0);
    chk("t6_idx", idx_a, 0);
    chk("t6_last", last_a, 0);
    chk("t6_busy", busy_a, 0);
    chk("t6_ready", rdy_a, 1);
    sb_a.delete();
    wait_first = 1'b0;
    @(posedge clk); #1;
    rst_n       = 1'b1;
    ready_force = 1'b1;
    @(posedge clk); #1;
    send_a({$urandom, $urandom}, 1'b1, 1'b0);
    wait_done_a();

    // Small instance: T1/T2 and random seeds
    run_b(16'h0000, 1'b0);
    run_b(16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_b(16'($urandom), 1'(i % 2));
    end

    chk("sb_a_empty", sb_a.size(), 0);
    chk("sb_b_empty", sb_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
